// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, stage enables and stall count out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rd_i;
    logic [4:0]       ifid_rs1_i;
    logic [4:0]       ifid_rs2_i;
    logic             branch_taken_i;
    logic             idex_mul_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             ex_hold_o;
    logic             busy_o;
    logic [CNT_W-1:0] stall_cycles_o;

    // CPU side: reports pipeline contents, consumes enables
    modport master (
        output start_i, idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
               branch_taken_i, idex_mul_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               ex_hold_o, busy_o, stall_cycles_o
    );

    // Controller side
    modport slave (
        input  start_i, idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
               branch_taken_i, idex_mul_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               ex_hold_o, busy_o, stall_cycles_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: run gating, load-use stall, branch flush,
// multi-cycle MUL hold and a saturating stall-cycle counter.
// Optional feature macro: HAZARD_CTRL_MUL_STALL_EN (MUL hold / MUL_WAIT state).
// Control outputs are Mealy: decoded from the registered state and live inputs.
module hazard_ctrl #(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef HAZARD_CTRL_MUL_STALL_EN
    localparam logic [1:0]  ST_MUL_WAIT = 2'd2;
    localparam int unsigned MUL_CW      = 5;
    localparam int unsigned MUL_LOAD    = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
    localparam bit          MUL_MULTI   = (MUL_LATENCY > 1);
`endif

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             ex_hold;
    logic             load_use;
    logic             stall_inc;

`ifdef HAZARD_CTRL_MUL_STALL_EN
    logic [MUL_CW-1:0] mul_cnt;
    logic [MUL_CW-1:0] mul_cnt_nxt;
    logic              mul_done;
    logic              mul_done_nxt;
    logic              mul_detect;

    // New MUL in EX that has not just finished its hold
    assign mul_detect = bus.idex_mul_i && MUL_MULTI && !mul_done;
`else
    // MUL is single-cycle in this build; inputs kept only to avoid dangling nets
    logic unused_mul;
    assign unused_mul = ^{bus.idex_mul_i, 32'(MUL_LATENCY)};
`endif

    // Load in EX writes a register the instruction in ID reads
    assign load_use = bus.idex_memread_i && (bus.idex_rd_i != 5'd0) &&
                      ((bus.idex_rd_i == bus.ifid_rs1_i) || (bus.idex_rd_i == bus.ifid_rs2_i));

    // Next-state and Mealy control decode; priority start low > MUL > load-use > branch
    always_comb begin
        state_nxt    = state;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        ex_hold      = 1'b0;
`ifdef HAZARD_CTRL_MUL_STALL_EN
        mul_cnt_nxt  = mul_cnt;
        mul_done_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.start_i) begin
                    state_nxt = ST_IDLE;
`ifdef HAZARD_CTRL_MUL_STALL_EN
                    mul_cnt_nxt = '0;
`endif
                end
`ifdef HAZARD_CTRL_MUL_STALL_EN
                else if (mul_detect) begin
                    ex_hold     = 1'b1;
                    mul_cnt_nxt = MUL_CW'(MUL_LOAD);
                    if (MUL_LOAD == 0) begin
                        mul_done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_MUL_WAIT;
                    end
                end
`endif
                else if (load_use) begin
                    idex_bubble = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = bus.branch_taken_i;
                end
            end
`ifdef HAZARD_CTRL_MUL_STALL_EN
            ST_MUL_WAIT: begin
                if (!bus.start_i) begin
                    state_nxt   = ST_IDLE;
                    mul_cnt_nxt = '0;
                end else begin
                    ex_hold     = 1'b1;
                    mul_cnt_nxt = mul_cnt - MUL_CW'(1);
                    if (mul_cnt == MUL_CW'(1)) begin
                        state_nxt    = ST_RUN;
                        mul_done_nxt = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and MUL countdown
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
`ifdef HAZARD_CTRL_MUL_STALL_EN
            mul_cnt  <= '0;
            mul_done <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
`ifdef HAZARD_CTRL_MUL_STALL_EN
            mul_cnt  <= mul_cnt_nxt;
            mul_done <= mul_done_nxt;
`endif
        end
    end

    assign stall_inc = (state != ST_IDLE) && !pc_write;

    // Saturating count of cycles where the PC was held while active
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_write_o     = pc_write;
    assign bus.ifid_write_o   = ifid_write;
    assign bus.ifid_flush_o   = ifid_flush;
    assign bus.idex_bubble_o  = idex_bubble;
    assign bus.ex_hold_o      = ex_hold;
    assign bus.busy_o         = (state != ST_IDLE);
    assign bus.stall_cycles_o = stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RISC-V CPU. It gates execution on `start_i` and detects load-use hazards. It flushes IF/ID on taken branches, stalls the front end while a multi-cycle multiply occupies EX, and counts stall cycles for performance reporting. It sits beside the CPU top level and drives the write enables of PC, IF/ID and ID/EX.

## Interface
- `MUL_LATENCY`, default 4: cycles a MUL occupies EX; legal range 1..16.
- `CNT_W`, default 16: width of the stall-cycle counter.

- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `start_i` input 1: run enable; low freezes the pipeline.
- `idex_memread_i` input 1: instruction in EX is a load.
- `idex_rd_i` input 5: destination register of the instruction in EX.
- `ifid_rs1_i` input 5: source register 1 of the instruction in ID.
- `ifid_rs2_i` input 5: source register 2 of the instruction in ID.
- `branch_taken_i` input 1: branch in ID resolved taken.
- `idex_mul_i` input 1: instruction in EX is a MUL.
- `pc_write_o` output 1: PC update enable.
- `ifid_write_o` output 1: IF/ID register update enable.
- `ifid_flush_o` output 1: zero IF/ID on the next edge.
- `idex_bubble_o` output 1: load a NOP into ID/EX on the next edge.
- `ex_hold_o` output 1: freeze ID/EX and EX/MEM, insert a bubble into MEM/WB.
- `busy_o` output 1: controller is not in IDLE.
- `stall_cycles_o` output CNT_W: saturating count of stalled cycles.

## Operation
- States: IDLE, RUN, MUL_WAIT. Reset state is IDLE.
- IDLE: all enables and controls are 0. `start_i`=1 moves the controller to RUN at the next edge.
- In RUN or MUL_WAIT, `start_i`=0 moves the controller to IDLE at the next edge. The MUL countdown and done flag are discarded; on restart a MUL still in EX is timed again from the beginning.
- RUN default: `pc_write_o`=`ifid_write_o`=1; all other controls 0.
- Load-use condition:
  - `idex_memread_i` is high, `idex_rd_i`≠0, and `idex_rd_i` equals `ifid_rs1_i` or `ifid_rs2_i`.
  - Response, in the same cycle: `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1.
  - Lasts exactly one cycle, because the load advances to MEM.
- Branch: `branch_taken_i` in RUN raises `ifid_flush_o`=1, but only when no load-use stall and no MUL hold are active. A stall suppresses the flush. The branch is re-evaluated after the stall releases.
- MUL detection happens in RUN when `idex_mul_i`=1, `MUL_LATENCY`>1 and the done flag is clear. In that cycle:
  - `ex_hold_o`=1, `pc_write_o`=0, `ifid_write_o`=0.
  - The counter loads `MUL_LATENCY`-2.
  - If that value is 0, the controller stays in RUN and sets the done flag. Otherwise it goes to MUL_WAIT.
- MUL_WAIT:
  - Same hold outputs as the detection cycle; no bubble, no flush.
  - Load-use is ignored because EX is frozen.
  - The counter decrements each cycle; at value 1 the controller moves to RUN and sets the done flag.
  - Total hold cycles per MUL = `MUL_LATENCY`-1.
- Done flag: suppresses re-detection of the same MUL for one cycle, then clears. A back-to-back MUL in the following cycle is detected normally.
- `stall_cycles_o` increments every cycle in which the state is not IDLE and `pc_write_o`=0. It saturates at all-ones and clears only on reset.
- `busy_o` = (state ≠ IDLE).

## Timing
- All control outputs are Mealy: combinational from the registered state and the current-cycle inputs. There is zero-cycle latency from a hazard input to its stall response.
- Reset values: state IDLE, counter 0, done flag 0, `stall_cycles_o`=0, every output 0.
- Priority when events coincide: `rst_i` > `start_i`=0 > MUL hold > load-use > branch flush.
- The first RUN cycle is the cycle after `start_i` is sampled high; PC advances at the end of that cycle.

## Configuration
- `HAZARD_CTRL_MUL_STALL_EN` defined: MUL detection and the MUL_WAIT state are compiled in, as described above.
- Not defined:
  - `idex_mul_i` is ignored, the MUL_WAIT state and the counter are absent, and `ex_hold_o` is tied to 0.
  - `MUL_LATENCY` is unused; MUL is treated as single-cycle.

## Test plan
- Reset then `start_i`=1 at cycle 2 -> `busy_o`=1 and `pc_write_o`=1 from cycle 3. While in reset all outputs are 0 and `stall_cycles_o`=0.
- `idex_memread_i`=1, `idex_rd_i`=5, `ifid_rs2_i`=5 for one cycle -> exactly one cycle of `pc_write_o`=0 and `idex_bubble_o`=1; `stall_cycles_o`=1. With `idex_rd_i`=0 -> no stall.
- `branch_taken_i`=1 in RUN -> `ifid_flush_o`=1 that cycle. `branch_taken_i` together with a load-use hazard -> flush 0 and bubble 1.
- MUL_LATENCY=4, `idex_mul_i` held high -> `ex_hold_o`=1 for exactly 3 cycles, then 0 for 1 cycle while still high; `stall_cycles_o`=3. With MUL_LATENCY=1 -> no hold.
- `start_i` dropped during MUL_WAIT -> IDLE next cycle. On restart with `idex_mul_i`=1 -> a full 3-cycle hold is repeated.
- `rst_i` pulsed mid-MUL_WAIT -> state IDLE, counter and `stall_cycles_o` are 0 at the next edge.
